inst_fetch_unit: RTL

//   Parametrised instruction fetch stage for the single-cycle/pipelined CPU labs.

---
 rtl/inst_fetch_unit_pkg.sv | 21 ++
 rtl/inst_fetch_unit_pc_gen.sv | 62 ++++++
 rtl/inst_fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_unit_pkg;

  // Byte increment between sequential fetches (one 32-bit word).
  localparam int IFU_PC_INCR = 4;

  // Source of the next fetch address, in priority order redirect > incr > hold.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INCR     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // A redirect target is misaligned when it is not on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_gen.sv
// Next-fetch PC register with redirect/increment/hold mux and sticky misalignment flag.
// Latency: pc updates on the clock edge after redirect_valid or incr is seen.
// Backpressure: incr low holds pc; the caller folds stall and fetch enable into incr.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   redirect_valid  load redirect_pc (word-aligned) as the next fetch address
//   redirect_pc     redirect target, byte address
//   incr            advance pc by one word
//   pc              next fetch address
//   misalign_err    sticky: some redirect target had non-zero low bits
module inst_fetch_unit_pc_gen
  import inst_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            incr,
  output logic [PC_W-1:0] pc,
  output logic            misalign_err
);

  pc_sel_e         sel;
  logic [PC_W-1:0] pc_next;

  always_comb begin
    sel = PC_HOLD;
    if (redirect_valid) begin
      sel = PC_REDIRECT;
    end else if (incr) begin
      sel = PC_INCR;
    end
  end

  always_comb begin
    pc_next = pc;
    case (sel)
      // Low bits are dropped so fetch always proceeds from the enclosing word.
      PC_REDIRECT: pc_next = {redirect_pc[PC_W-1:2], 2'b00};
      // Natural modulo 2^PC_W wrap.
      PC_INCR:     pc_next = pc + PC_W'(IFU_PC_INCR);
      default:     pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      pc <= pc_next;
      if (redirect_valid && is_misaligned(redirect_pc[1:0])) begin
        misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: drives a synchronous 1-cycle ROM and presents instructions to decode.
// Latency: first instruction 1 cycle after reset release; redirect costs one bubble (target at n+2).
// Backpressure: inst_ready low holds inst_code/inst_pc by re-reading the held address; no loss/dup.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fetch_en        1 = issue new fetches, 0 = drain without new ROM requests
//   redirect_valid  redirect to redirect_pc, squashing the in-flight instruction
//   redirect_pc     redirect target, byte address
//   inst_ready      decode accepts inst_code this cycle
//   rom_addr        word address to the ROM (combinational)
//   rom_data        ROM output for the address presented on the previous cycle
//   inst_valid      inst_code/inst_pc valid
//   inst_code       fetched instruction
//   inst_pc         byte address of inst_code
//   misalign_err    sticky misaligned-redirect flag
//   fetch_count     accepted instructions, wraps
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 6,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_code,
  output logic [PC_W-1:0]   inst_pc,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] f_pc;
  logic            f_valid;
  logic            advance;

  // The ROM output slot is free when empty or being consumed this cycle.
  assign advance = ~f_valid | inst_ready;

  inst_fetch_unit_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .incr           (advance & fetch_en),
    .pc             (pc),
    .misalign_err   (misalign_err)
  );

  // While stalled the held address is re-read so rom_data stays stable.
  // Upper pc bits are truncated here, aliasing the ROM; inst_pc keeps the full value.
  assign rom_addr   = advance ? pc[ADDR_W+1:2] : f_pc[ADDR_W+1:2];

  // A redirect squashes the instruction on rom_data in the same cycle.
  assign inst_valid = f_valid & ~redirect_valid;
  assign inst_code  = rom_data;
  assign inst_pc    = f_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_pc    <= '0;
      f_valid <= 1'b0;
    end else if (redirect_valid) begin
      f_valid <= 1'b0;
    end else if (advance) begin
      if (fetch_en) begin
        f_pc    <= pc;
        f_valid <= 1'b1;
      end else begin
        f_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (inst_valid && inst_ready) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
